// File: rtl/sd_spi_master.sv
// sd_spi_master: mode-0 SPI byte shifter for the SD card slot, MSB first, SCK = fclk/(2*HALF)
module sd_spi_master #(
    parameter int HALF = 1
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       sd_start,
    input  logic [7:0] sd_datain,
    output logic [7:0] sd_dataout,
    output logic       busy,
    output logic       sdclk,
    output logic       sddo,
    input  logic       sdi
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
    localparam logic [7:0] LAST = 8'(HALF - 1);
    state_t      r_state, w_nxt;
    logic [7:0]  r_hcnt, r_tx, r_rx;
    logic [2:0]  r_bcnt;
    logic        w_tick, w_start, w_fall, w_done;
    always_comb begin
        w_tick  = r_hcnt == LAST;
        w_start = r_state == IDLE && sd_start;
        w_fall  = r_state == HIGH && w_tick;
        w_done  = w_fall && r_bcnt == 3'd7;
        w_nxt   = r_state;
        w_nxt   = r_state == IDLE ? (sd_start ? LOW : IDLE) :
                  !w_tick         ? r_state :
                  r_state == LOW  ? HIGH :
                  w_done          ? IDLE : LOW;
    end
    always_ff @(posedge fclk or posedge rst)
        if (rst) r_state <= IDLE;
        else r_state <= w_nxt;
    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_hcnt     <= 8'd0;
            r_bcnt     <= 3'd0;
            r_tx       <= 8'hFF;
            r_rx       <= 8'h00;
            sd_dataout <= 8'hFF;
            busy       <= 1'b0;
            sdclk      <= 1'b0;
            sddo       <= 1'b1;
        end else begin
            r_hcnt <= (r_state == IDLE || w_tick) ? 8'd0 : r_hcnt + 8'd1;
            if (w_start) begin
                r_tx   <= sd_datain;
                sddo   <= sd_datain[7];
                r_bcnt <= 3'd0;
                busy   <= 1'b1;
            end
            if (r_state == LOW && w_tick) sdclk <= 1'b1;
            // end of high phase: sample MISO, then advance MOSI or finish the byte
            if (w_fall) begin
                sdclk <= 1'b0;
                r_rx  <= {r_rx[6:0], sdi};
                if (w_done) begin
                    sd_dataout <= {r_rx[6:0], sdi};
                    busy       <= 1'b0;
                    sddo       <= 1'b1;
                end else begin
                    r_bcnt <= r_bcnt + 3'd1;
                    r_tx   <= {r_tx[6:0], 1'b1};
                    sddo   <= r_tx[6];
                end
            end
        end
    end
endmodule
